dmem_resp: RTL and testbench

- Data-memory responder: the memory-side end of the start/adr/load/in/siz → out/busy/done handshake driven by the reservation-station load/store path.
- Byte-addressed, little-endian, single-port storage behind a fixed-latency FSM.
- Accepts one request at a time and returns one done pulse per request.
- Supports RV32 LB/LH/LW/LBU/LHU and SB/SH/SW.

---
 rtl/dmem_resp.sv | 194 +++++++++++++++++++
 tb/tb_dmem_resp.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: byte-addressed little-endian storage behind a fixed-latency
// start/done handshake, serving RV32 loads and stores one request at a time.
module dmem_resp #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_start,
   input  logic [31:0] mem_adr,
   input  logic        mem_load,
   input  logic [31:0] mem_in,
   input  logic [2:0]  mem_siz,
   output logic [31:0] mem_out,
   output logic        mem_busy,
   output logic        mem_done,
   output logic        mem_err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic                load_q, load_d;
   logic [31:0]         in_q, in_d;
   logic [2:0]          siz_q, siz_d;
   logic                bad_q, bad_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [31:0]         out_q, out_d;

   logic [7:0]          mem_q [DEPTH];

   logic                accept_c;
   logic                commit_c;
   logic                illegal_c;
   logic [ADDR_W-1:0]   a1_c, a2_c, a3_c;
   logic [7:0]          b0_c, b1_c, b2_c, b3_c;
   logic [31:0]         rdata_c;
   logic                unused_adr_c;

   assign unused_adr_c = ^mem_adr[31:ADDR_W];

   // A new request may be taken from IDLE or on the edge leaving RESP (back-to-back).
   assign accept_c = mem_start && ((state_q == IDLE) || (state_q == RESP));
   assign commit_c = (state_q == WAIT) && (cnt_q == '0);

   // Legality is decided from the request as presented on the accept edge.
   always_comb begin
      illegal_c = 1'b0;
      case (mem_siz)
         3'b011, 3'b110, 3'b111: illegal_c = 1'b1;
         3'b100, 3'b101:         illegal_c = mem_load;
         default:                illegal_c = 1'b0;
      endcase
      if ((mem_siz[1:0] == 2'b01) && mem_adr[0])
         illegal_c = 1'b1;
      if ((mem_siz == 3'b010) && (mem_adr[1:0] != 2'b00))
         illegal_c = 1'b1;
   end

   assign a1_c = adr_q + ADDR_W'(1);
   assign a2_c = adr_q + ADDR_W'(2);
   assign a3_c = adr_q + ADDR_W'(3);
   assign b0_c = mem_q[adr_q];
   assign b1_c = mem_q[a1_c];
   assign b2_c = mem_q[a2_c];
   assign b3_c = mem_q[a3_c];

   always_comb begin
      rdata_c = out_q;
      case (siz_q)
         3'b000:  rdata_c = {{24{b0_c[7]}}, b0_c};
         3'b001:  rdata_c = {{16{b1_c[7]}}, b1_c, b0_c};
         3'b010:  rdata_c = {b3_c, b2_c, b1_c, b0_c};
         3'b100:  rdata_c = {24'd0, b0_c};
         3'b101:  rdata_c = {16'd0, b1_c, b0_c};
         default: rdata_c = out_q;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      load_d  = load_q;
      in_d    = in_q;
      siz_d   = siz_q;
      bad_d   = bad_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      out_d   = out_q;

      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (accept_c) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               adr_d   = mem_adr[ADDR_W-1:0];
               load_d  = mem_load;
               in_d    = mem_in;
               siz_d   = mem_siz;
               bad_d   = illegal_c;
               busy_d  = 1'b1;
            end
         end
         WAIT: begin
            if (commit_c) begin
               state_d = RESP;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               err_d   = bad_q;
               if (!load_q && !bad_q)
                  out_d = rdata_c;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         load_q  <= 1'b0;
         in_q    <= '0;
         siz_q   <= '0;
         bad_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         load_q  <= load_d;
         in_q    <= in_d;
         siz_q   <= siz_d;
         bad_q   <= bad_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         out_q   <= out_d;
      end
   end

   // Storage is never reset; stores commit on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (commit_c && load_q && !bad_q) begin
         case (siz_q)
            3'b000: begin
               mem_q[adr_q] <= in_q[7:0];
            end
            3'b001: begin
               mem_q[adr_q] <= in_q[7:0];
               mem_q[a1_c]  <= in_q[15:8];
            end
            3'b010: begin
               mem_q[adr_q] <= in_q[7:0];
               mem_q[a1_c]  <= in_q[15:8];
               mem_q[a2_c]  <= in_q[23:16];
               mem_q[a3_c]  <= in_q[31:24];
            end
            default: ;
         endcase
      end
   end

   assign mem_out  = out_q;
   assign mem_busy = busy_q;
   assign mem_done = done_q;
   assign mem_err  = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed and randomized requests against a byte-array memory model.
module tb_dmem_resp;

   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_start;
   logic [31:0] mem_adr;
   logic        mem_load;
   logic [31:0] mem_in;
   logic [2:0]  mem_siz;
   logic [31:0] mem_out;
   logic        mem_busy;
   logic        mem_done;
   logic        mem_err;

   int unsigned vec  = 0;
   int unsigned miss = 0;
   logic [7:0]  ref_mem [65536];
   logic [31:0] ref_out;

   dmem_resp #(.ADDR_W(16), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_start (mem_start),
      .mem_adr   (mem_adr),
      .mem_load  (mem_load),
      .mem_in    (mem_in),
      .mem_siz   (mem_siz),
      .mem_out   (mem_out),
      .mem_busy  (mem_busy),
      .mem_done  (mem_done),
      .mem_err   (mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_legal(input logic [31:0] adr, input logic ld, input logic [2:0] siz);
      int unsigned nbytes;
      if (siz == 3'd3 || siz == 3'd6 || siz == 3'd7) return 1'b0;
      if (ld && siz > 3'd2) return 1'b0;
      nbytes = 1 << siz[1:0];
      return (adr % nbytes) == 0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] adr, input logic [2:0] siz);
      int unsigned a;
      logic [31:0] w;
      a = adr % 65536;
      w = {ref_mem[(a + 3) % 65536], ref_mem[(a + 2) % 65536],
           ref_mem[(a + 1) % 65536], ref_mem[a]};
      case (siz)
         3'd0:    return 32'($signed(w[7:0]));
         3'd1:    return 32'($signed(w[15:0]));
         3'd2:    return w;
         3'd4:    return {24'd0, w[7:0]};
         3'd5:    return {16'd0, w[15:0]};
         default: return ref_out;
      endcase
   endfunction

   task automatic ref_write(input logic [31:0] adr, input logic [31:0] din, input logic [2:0] siz);
      int unsigned a;
      a = adr % 65536;
      for (int i = 0; i < (1 << siz[1:0]); i++)
         ref_mem[(a + i) % 65536] = din[8*i +: 8];
   endtask

   // One complete request: accept, watch busy until done, compare against the model.
   task automatic do_req(input string tag, input logic [31:0] adr, input logic ld,
                         input logic [31:0] din, input logic [2:0] siz);
      bit ok;
      bit busy_bad;
      int k;
      ok = ref_legal(adr, ld, siz);
      busy_bad = 1'b0;
      @(negedge clk);
      mem_start = 1'b1;
      mem_adr   = adr;
      mem_load  = ld;
      mem_in    = din;
      mem_siz   = siz;
      @(posedge clk);
      @(negedge clk);
      mem_start = 1'b0;
      k = 0;
      while (!mem_done && k < 20) begin
         if (!mem_busy) busy_bad = 1'b1;
         @(negedge clk);
         k++;
      end
      if (!mem_done) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         if (ok && ld) ref_write(adr, din, siz);
         if (ok && !ld) ref_out = ref_read(adr, siz);
         chk({tag, "_lat"}, 32'(k), 32'(LAT));
         chk({tag, "_busy_at_done"}, 32'(mem_busy), 32'd0);
         chk({tag, "_err"}, 32'(mem_err), 32'(!ok));
         chk({tag, "_out"}, mem_out, ref_out);
         chk({tag, "_busy_held"}, 32'(busy_bad), 32'd0);
         @(negedge clk);
         chk({tag, "_done_pulse"}, 32'(mem_done), 32'd0);
      end
   endtask

   initial begin
      int dones;
      int t_done [3];
      rst_n     = 1'b0;
      mem_start = 1'b0;
      mem_adr   = '0;
      mem_load  = 1'b0;
      mem_in    = '0;
      mem_siz   = '0;
      ref_out   = '0;
      #1;
      chk("rst_busy", 32'(mem_busy), 32'd0);
      chk("rst_done", 32'(mem_done), 32'd0);
      chk("rst_err",  32'(mem_err),  32'd0);
      chk("rst_out",  mem_out,       32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed loads and stores around one word.
      do_req("sw",  32'h100, 1'b1, 32'hDEADBEEF, 3'd2);
      do_req("lw",  32'h100, 1'b0, 32'h0, 3'd2);
      do_req("lb",  32'h103, 1'b0, 32'h0, 3'd0);
      do_req("lbu", 32'h103, 1'b0, 32'h0, 3'd4);
      do_req("lh",  32'h100, 1'b0, 32'h0, 3'd1);
      do_req("lhu", 32'h102, 1'b0, 32'h0, 3'd5);
      do_req("sb",  32'h101, 1'b1, 32'h12345677, 3'd0);
      do_req("lw2", 32'h100, 1'b0, 32'h0, 3'd2);
      do_req("sh",  32'h102, 1'b1, 32'hAAAA0000, 3'd1);
      do_req("lw3", 32'h100, 1'b0, 32'h0, 3'd2);
      chk("lw3_const", mem_out, 32'h000077EF);

      // Illegal requests: misaligned, bad write size, reserved codes.
      do_req("lw_mis",  32'h102, 1'b0, 32'h0, 3'd2);
      do_req("sw_mis",  32'h101, 1'b1, 32'hCAFEF00D, 3'd2);
      do_req("lw_chk",  32'h100, 1'b0, 32'h0, 3'd2);
      do_req("lh_odd",  32'h101, 1'b0, 32'h0, 3'd1);
      do_req("sbu_bad", 32'h100, 1'b1, 32'h55, 3'd4);
      do_req("siz3",    32'h100, 1'b0, 32'h0, 3'd3);
      do_req("siz7",    32'h100, 1'b1, 32'h0, 3'd7);
      do_req("lw_chk2", 32'h100, 1'b0, 32'h0, 3'd2);

      // Address wrap: upper bits ignored.
      do_req("sw_wrap", 32'h0001_0100, 1'b1, 32'h0BADC0DE, 3'd2);
      do_req("lw_wrap", 32'h100, 1'b0, 32'h0, 3'd2);

      // Start held high: three back-to-back loads.
      @(negedge clk);
      mem_start = 1'b1;
      mem_adr   = 32'h100;
      mem_load  = 1'b0;
      mem_siz   = 3'd2;
      @(posedge clk);
      dones = 0;
      for (int k = 0; k < 30 && dones < 3; k++) begin
         @(negedge clk);
         if (mem_done) begin
            t_done[dones] = k;
            dones++;
            if (dones == 3) mem_start = 1'b0;
         end
      end
      ref_out = ref_read(32'h100, 3'd2);
      chk("b2b_count", 32'(dones), 32'd3);
      if (dones == 3) begin
         chk("b2b_t0", 32'(t_done[0]), 32'(LAT));
         chk("b2b_t1", 32'(t_done[1]), 32'(2 * LAT + 1));
         chk("b2b_t2", 32'(t_done[2]), 32'(3 * LAT + 2));
      end
      chk("b2b_out", mem_out, ref_out);
      repeat (2) @(negedge clk);

      // A start pulse during busy is ignored, no extra done, no write.
      mem_start = 1'b1;
      mem_adr   = 32'h100;
      mem_load  = 1'b0;
      mem_siz   = 3'd2;
      @(posedge clk);
      @(negedge clk);
      mem_start = 1'b0;
      @(negedge clk);
      mem_start = 1'b1;
      mem_load  = 1'b1;
      mem_in    = 32'h11111111;
      @(negedge clk);
      mem_start = 1'b0;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         if (mem_done) dones++;
         @(negedge clk);
      end
      chk("ignore_done_count", 32'(dones), 32'd1);
      do_req("ignore_lw", 32'h100, 1'b0, 32'h0, 3'd2);

      // Reset in the middle of a store: dropped, no done, memory untouched.
      @(negedge clk);
      mem_start = 1'b1;
      mem_adr   = 32'h100;
      mem_load  = 1'b1;
      mem_in    = 32'h5555AAAA;
      mem_siz   = 3'd2;
      @(posedge clk);
      @(negedge clk);
      mem_start = 1'b0;
      chk("abort_busy_before", 32'(mem_busy), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(mem_busy), 32'd0);
      chk("abort_done", 32'(mem_done), 32'd0);
      chk("abort_out",  mem_out, 32'd0);
      ref_out = '0;
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mem_done || mem_busy) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      do_req("abort_lw", 32'h100, 1'b0, 32'h0, 3'd2);

      // Randomized traffic over a pre-filled region, upper address bits scrambled.
      for (int i = 0; i < 16; i++)
         do_req("fill", 32'h300 + 32'(4 * i), 1'b1, $urandom, 3'd2);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         logic [2:0]  s;
         logic        l;
         a = ($urandom << 16) | (32'h300 + ($urandom % 64));
         s = 3'($urandom % 8);
         l = 1'($urandom % 2);
         do_req("rnd", a, l, $urandom, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
